// File: rtl/reg_bank_sr.sv
// reg_bank_sr: WIDTH-bit register with parallel load, serial shift, rotate
// and binary count, plus per-bit synchronous set/clear overrides.
// Synchronous active-high reset loads RESET_VALUE.
// Optional macro REG_BANK_SR_DIR_SEL_EN adds a dir input selecting
// right shift / right rotate / count down when dir=1.
module reg_bank_sr #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
`ifdef REG_BANK_SR_DIR_SEL_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq,
  output logic             ser_out,
  output logic             tc
);

  localparam logic [1:0] MODE_LOAD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

  // Direction select: right/down when 1; tied to left/up when the option is absent.
  logic dir_sel;
`ifdef REG_BANK_SR_DIR_SEL_EN
  assign dir_sel = dir;
`else
  assign dir_sel = 1'b0;
`endif

  logic [WIDTH-1:0] mode_result;
  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] q_next;

  // Result of the selected mode operation applied to the current contents.
  always_comb begin
    mode_result = q;
    unique case (mode)
      MODE_LOAD:   mode_result = d;
      MODE_SHIFT:  mode_result = dir_sel ? {ser_in, q[WIDTH-1:1]}
                                         : {q[WIDTH-2:0], ser_in};
      MODE_ROTATE: mode_result = dir_sel ? {q[0], q[WIDTH-1:1]}
                                         : {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_COUNT:  mode_result = dir_sel ? q - WIDTH'(1)
                                         : q + WIDTH'(1);
      default:     mode_result = q;
    endcase
  end

  // Next state: mode result when enabled, then set, then clear (clear wins).
  always_comb begin
    op_result = en ? mode_result : q;
    q_next    = (op_result | set) & ~clr;
  end

  // State register with synchronous reset overriding everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= q_next;
    end
  end

  // Combinational views of the register contents.
  always_comb begin
    notq    = ~q;
    ser_out = dir_sel ? q[0] : q[WIDTH-1];
    tc      = en && (mode == MODE_COUNT) &&
              (dir_sel ? (q == ALL_ZEROS) : (q == ALL_ONES));
  end

endmodule

// File: tb/tb_reg_bank_sr.sv
// tb_reg_bank_sr: randomized and directed checks of reg_bank_sr (WIDTH=8,
// RESET_VALUE=8'hA5) against an arithmetic reference model.
module tb_reg_bank_sr;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;
  logic             dir;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] notq;
  logic             ser_out;
  logic             tc;

  int checks = 0;
  int errors = 0;
  int mq     = 0;   // model register contents, 0..255

  reg_bank_sr #(.WIDTH(WIDTH), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .ser_in(ser_in),
    .set(set), .clr(clr),
`ifdef REG_BANK_SR_DIR_SEL_EN
    .dir(dir),
`endif
    .q(q), .notq(notq), .ser_out(ser_out), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference next value computed with plain arithmetic on integers.
  function automatic int model_next(int cur);
    int r;
    int s, c, bit_val;
    if (rst) return 'hA5;
    r = cur;
    if (en) begin
      case (int'(mode))
        0: r = int'(d);
        1: r = dir ? (int'(ser_in) * 128 + cur / 2) : ((cur * 2 + int'(ser_in)) % 256);
        2: r = dir ? ((cur % 2) * 128 + cur / 2) : ((cur * 2 + cur / 128) % 256);
        default: r = dir ? ((cur + 255) % 256) : ((cur + 1) % 256);
      endcase
    end
    s = int'(set);
    c = int'(clr);
    for (int i = 0; i < 8; i++) begin
      bit_val = (r >> i) % 2;
      if ((s >> i) % 2 == 1) bit_val = 1;
      if ((c >> i) % 2 == 1) bit_val = 0;
      r = r - ((r >> i) % 2) * (1 << i) + bit_val * (1 << i);
    end
    return r;
  endfunction

  // One clock: update model, then sample outputs after the edge.
  task automatic cycle(input string tag);
    int exp_tc, exp_so;
    mq = model_next(mq);
    @(posedge clk);
    #1;
    exp_so = dir ? (mq % 2) : (mq / 128);
    exp_tc = (en && mode == 2'b11 && (dir ? (mq == 0) : (mq == 255))) ? 1 : 0;
    check({tag, "_q"},    32'(q),       32'(mq));
    check({tag, "_notq"}, 32'(notq),    32'(255 - mq));
    check({tag, "_so"},   32'(ser_out), 32'(exp_so));
    check({tag, "_tc"},   32'(tc),      32'(exp_tc));
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] dd, input logic si,
                       input logic [7:0] s, input logic [7:0] c);
    rst = r; en = e; mode = m; d = dd; ser_in = si; set = s; clr = c;
  endtask

  initial begin
    dir = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00);
    #1;
    cycle("reset");
    check("reset_q_abs", 32'(q), 32'hA5);
    check("reset_notq_abs", 32'(notq), 32'h5A);
    check("reset_so_abs", 32'(ser_out), 32'd1);

    // count through all-ones to zero
    drive(1'b0, 1'b1, 2'b00, 8'hFE, 1'b0, 8'h00, 8'h00); cycle("load_fe");
    drive(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 8'h00); cycle("cnt_ff");
    check("cnt_ff_abs", {31'd0, tc}, 32'd1);
    cycle("cnt_wrap");
    check("cnt_wrap_abs", 32'(q), 32'h00);

    // shift and rotate from 8'h81
    drive(1'b0, 1'b1, 2'b00, 8'h81, 1'b0, 8'h00, 8'h00); cycle("load_81a");
    drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 8'h00); cycle("shl");
    check("shl_abs", 32'(q), 32'h02);
    drive(1'b0, 1'b1, 2'b00, 8'h81, 1'b0, 8'h00, 8'h00); cycle("load_81b");
    drive(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 8'h00, 8'h00); cycle("rol");
    check("rol_abs", 32'(q), 32'h03);

    // load with per-bit set and clear
    drive(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00); cycle("load_00");
    drive(1'b0, 1'b1, 2'b00, 8'h3C, 1'b0, 8'h01, 8'h04); cycle("load_sc");
    check("load_sc_abs", 32'(q), 32'h39);

    // clear beats set, count suppressed by en=0
    drive(1'b0, 1'b1, 2'b00, 8'h7F, 1'b0, 8'h00, 8'h00); cycle("load_7f");
    drive(1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 8'h80, 8'h80); cycle("clr_wins");
    check("clr_wins_abs", 32'(q), 32'h7F);

    // reset mid-count aborts the increment
    drive(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 8'h00); cycle("cnt_pre");
    drive(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 8'hFF, 8'h00); cycle("rst_mid");

`ifdef REG_BANK_SR_DIR_SEL_EN
    dir = 1'b1;
    drive(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00); cycle("dn_load0");
    drive(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 8'h00);
    #1;
    check("dn_tc", {31'd0, tc}, 32'd1);
    cycle("dn_cnt");
    check("dn_cnt_abs", 32'(q), 32'hFF);
    drive(1'b0, 1'b1, 2'b00, 8'h02, 1'b0, 8'h00, 8'h00); cycle("dn_load2");
    drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 8'h00, 8'h00); cycle("shr");
    check("shr_abs", 32'(q), 32'h81);
    dir = 1'b0;
`endif

    // randomized operation with sparse set/clr and occasional reset
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 32) == 0, ($urandom % 4) != 0, 2'($urandom),
            8'($urandom), 1'($urandom),
            8'($urandom & $urandom & $urandom), 8'($urandom & $urandom & $urandom));
`ifdef REG_BANK_SR_DIR_SEL_EN
      dir = 1'($urandom);
`endif
      // periodically steer toward the count boundaries
      if (n % 50 == 10) begin
        drive(1'b0, 1'b1, 2'b00, 8'hFD, 1'b0, 8'h00, 8'h00);
      end
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
